// File: rtl/change_dispenser.sv
// Purpose: pays out a change amount greedily, one coin per request/ack handshake.
// Latency: first eject two cycles after the accepted request, next eject two cycles after each coin_ack.
// Backpressure: new requests are ignored while busy; each coin waits for coin_ack or times out into a fault.
module change_dispenser #(
    parameter int AMT_W   = 3,
    parameter int COIN_HI = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AMT_W-1:0] change,
    input  logic             change_vld,
    input  logic             hi_empty,
    input  logic             lo_empty,
    input  logic             coin_ack,
    output logic             eject_hi,
    output logic             eject_lo,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] shortfall
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AMT_W-1:0] HI_VAL = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0] LO_VAL = AMT_W'(1);
    localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] remaining, remaining_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             coin_is_hi, coin_is_hi_nxt;
    logic             accept;

    assign accept = (state == S_IDLE) && change_vld;

    // Next-state, amount and timer logic; hopper flags only matter when choosing a coin.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        timer_nxt      = timer;
        coin_is_hi_nxt = coin_is_hi;
        case (state)
            S_IDLE: begin
                if (change_vld) begin
                    state_nxt     = S_SEL;
                    remaining_nxt = change;
                end
            end
            S_SEL: begin
                if (remaining == '0) begin
                    state_nxt = S_DONE;
                end else if ((remaining >= HI_VAL) && !hi_empty) begin
                    state_nxt      = S_EJECT;
                    coin_is_hi_nxt = 1'b1;
                end else if (!lo_empty) begin
                    state_nxt      = S_EJECT;
                    coin_is_hi_nxt = 1'b0;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
            S_EJECT: begin
                state_nxt = S_WAIT_ACK;
                timer_nxt = '0;
            end
            S_WAIT_ACK: begin
                // An ack arriving on the final wait cycle still counts as paid.
                if (coin_ack) begin
                    remaining_nxt = remaining - (coin_is_hi ? HI_VAL : LO_VAL);
                    state_nxt     = S_SEL;
                end else if (timer == T_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            timer      <= '0;
            coin_is_hi <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            timer      <= timer_nxt;
            coin_is_hi <= coin_is_hi_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eject_hi  <= 1'b0;
            eject_lo  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            shortfall <= '0;
        end else begin
            eject_hi <= (state_nxt == S_EJECT) && coin_is_hi_nxt;
            eject_lo <= (state_nxt == S_EJECT) && !coin_is_hi_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE) || (state_nxt == S_FAULT);
            if (accept) begin
                fault     <= 1'b0;
                shortfall <= '0;
            end else if (state_nxt == S_FAULT) begin
                fault     <= 1'b1;
                shortfall <= remaining_nxt;
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Purpose: directed self-checking bench for change_dispenser.
// Latency: observes outputs on the falling edge, drives inputs 1 ns after the rising edge.
// Backpressure: a bench-side hopper model acks each coin one cycle after its eject when enabled.
module tb_change_dispenser;

    localparam int AMT_W   = 3;
    localparam int COIN_HI = 2;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [AMT_W-1:0] change = '0;
    logic             change_vld = 1'b0;
    logic             hi_empty = 1'b0;
    logic             lo_empty = 1'b0;
    logic             coin_ack = 1'b0;
    logic             eject_hi, eject_lo, busy, done, fault;
    logic [AMT_W-1:0] shortfall;

    int n_checks = 0;
    int n_fail   = 0;

    // Hopper model and observation state.
    bit ack_en    = 1'b1;
    bit ack_next  = 1'b0;
    bit stray_ack = 1'b0;
    int cyc = 0;
    int n_hi, n_lo, n_done, seq;
    int req_cyc, first_ej_cyc, second_ej_cyc, done_cyc;
    bit busy_at_done;

    change_dispenser #(.AMT_W(AMT_W), .COIN_HI(COIN_HI), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .change     (change),
        .change_vld (change_vld),
        .hi_empty   (hi_empty),
        .lo_empty   (lo_empty),
        .coin_ack   (coin_ack),
        .eject_hi   (eject_hi),
        .eject_lo   (eject_lo),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .shortfall  (shortfall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        n_hi = 0; n_lo = 0; n_done = 0; seq = 0;
        first_ej_cyc = -1; second_ej_cyc = -1; done_cyc = -1;
        busy_at_done = 1'b0;
    endtask

    // One clock cycle: observe this cycle's outputs, then apply next cycle's coin_ack.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (eject_hi || eject_lo) begin
            if (first_ej_cyc < 0) first_ej_cyc = cyc;
            else if (second_ej_cyc < 0) second_ej_cyc = cyc;
        end
        if (eject_hi) begin n_hi++; seq = seq * 10 + 2; end
        if (eject_lo) begin n_lo++; seq = seq * 10 + 1; end
        if (done) begin
            n_done++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        ack_next = ack_en && (eject_hi || eject_lo);
        @(posedge clk);
        #1;
        coin_ack = ack_next || stray_ack;
    endtask

    task automatic request(input int amt);
        change     = AMT_W'(amt);
        change_vld = 1'b1;
        tick();
        req_cyc    = cyc;
        change_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start = n_done;
        for (int i = 0; i < budget && n_done == start; i++) tick();
        if (n_done == start) check({tag, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        clear_obs();
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_eject", {eject_hi, eject_lo}, 0);
        check("rst_shortfall", shortfall, 0);
        @(posedge clk); #1; rst = 1'b1;
        tick(); tick();

        // 1: change=5, both stocked -> hi, hi, lo.
        clear_obs();
        request(5);
        wait_done("t1", 100);
        check("t1_busy_at_done", busy_at_done, 1);
        tick();
        check("t1_busy_after", busy, 0);
        tick(); tick();
        check("t1_order", seq, 221);
        check("t1_done_cnt", n_done, 1);
        check("t1_fault", fault, 0);
        check("t1_shortfall", shortfall, 0);
        check("t1_first_latency", first_ej_cyc - req_cyc, 2);
        check("t1_eject_spacing", second_ej_cyc - first_ej_cyc, 3);

        // 2: high hopper empty -> three 1-unit coins.
        clear_obs();
        hi_empty = 1'b1;
        request(3);
        wait_done("t2", 100);
        tick(); tick();
        hi_empty = 1'b0;
        check("t2_order", seq, 111);
        check("t2_hi_cnt", n_hi, 0);
        check("t2_done_cnt", n_done, 1);
        check("t2_fault", fault, 0);

        // 3: low hopper empty -> one hi coin then fault with 1 unpaid.
        clear_obs();
        lo_empty = 1'b1;
        request(3);
        wait_done("t3", 100);
        tick(); tick(); tick();
        check("t3_hi_cnt", n_hi, 1);
        check("t3_lo_cnt", n_lo, 0);
        check("t3_done_cnt", n_done, 1);
        check("t3_fault_sticky", fault, 1);
        check("t3_shortfall", shortfall, 1);
        clear_obs();
        request(0);
        wait_done("t3z", 20);
        tick();
        check("t3z_ejects", n_hi + n_lo, 0);
        check("t3z_done_cnt", n_done, 1);
        check("t3z_fault", fault, 0);
        check("t3z_shortfall", shortfall, 0);
        lo_empty = 1'b0;

        // 4: no ack ever -> single hi eject, then timeout fault.
        clear_obs();
        ack_en = 1'b0;
        request(2);
        wait_done("t4", 60);
        for (int i = 0; i < 5; i++) tick();
        check("t4_hi_cnt", n_hi, 1);
        check("t4_lo_cnt", n_lo, 0);
        check("t4_fault", fault, 1);
        check("t4_shortfall", shortfall, 2);
        check("t4_done_cnt", n_done, 1);
        check("t4_timeout_window",
              int'((done_cyc - first_ej_cyc) >= TIMEOUT && (done_cyc - first_ej_cyc) <= TIMEOUT + 2), 1);
        ack_en = 1'b1;

        // 5: a second request while waiting for an ack is dropped.
        clear_obs();
        request(4);
        tick(); tick();
        change     = 3'd7;
        change_vld = 1'b1;
        tick();
        change_vld = 1'b0;
        wait_done("t5", 100);
        for (int i = 0; i < 6; i++) tick();
        check("t5_hi_cnt", n_hi, 2);
        check("t5_lo_cnt", n_lo, 0);
        check("t5_done_cnt", n_done, 1);
        check("t5_fault", fault, 0);
        clear_obs();
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick(); tick(); tick();
        check("t5_stray_ejects", n_hi + n_lo, 0);
        check("t5_stray_done", n_done, 0);
        check("t5_stray_busy", busy, 0);

        // 6: asynchronous reset while waiting for an ack.
        clear_obs();
        ack_en = 1'b0;
        request(3);
        tick(); tick(); tick();
        check("t6_busy_before_rst", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_eject", {eject_hi, eject_lo}, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_fault", fault, 0);
        check("t6_rst_shortfall", shortfall, 0);
        @(posedge clk); #1; rst = 1'b1;
        ack_en = 1'b1;
        tick();
        clear_obs();
        request(1);
        wait_done("t6", 40);
        tick();
        check("t6_order", seq, 1);
        check("t6_done_cnt", n_done, 1);
        check("t6_fault", fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
